mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory (synchronous read, 1-cycle latency) between the

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_fairness.sv | 56 +++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and grant encoding.
// Combinational helpers only, no state.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } arb_gnt_t;

    function automatic arb_state_t resp_state(input arb_gnt_t gnt);
        case (gnt)
            GNT_I:   return RESP_I;
            GNT_D:   return RESP_D;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// Grant decision for the unified memory: data first, fetch forced after a data streak.
// Latency: grant is combinational in the issue cycle; streak updates at the end of it.
// Backpressure: none; a requester without grant simply holds its request.
module mem_arb_fairness
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_req,
    input  logic     d_req,
    input  logic     issue,
    output arb_gnt_t gnt
);

    localparam int SW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_BURST);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    always_comb begin
        gnt = GNT_NONE;
        if (issue) begin
            if (d_req && (!i_req || streak_q != STREAK_MAX)) begin
                gnt = GNT_D;
            end else if (i_req) begin
                gnt = GNT_I;
            end
        end

        // Streak only counts data grants that actually made a fetch wait.
        streak_d = streak_q;
        case (gnt)
            GNT_I: streak_d = '0;
            GNT_D: begin
                if (!i_req) begin
                    streak_d = '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + SW'(1);
                end
            end
            default: streak_d = streak_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between the fetch and load/store ports of the core.
// Latency: 2 cycles per access (issue, then ack with read data); one access in flight.
// Backpressure: requests are held until their 1-cycle ack; the losing port waits.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       i_ack_q;
    logic       i_ack_d;
    logic       d_ack_q;
    logic       d_ack_d;
    arb_gnt_t   gnt;
    logic       issue;

    // Reset in the issue cycle kills the grant, so nothing reaches the memory.
    assign issue = (state_q == IDLE) && !reset;

    mem_arb_fairness #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_fairness (
        .clk  (clk),
        .reset(reset),
        .i_req(i_req),
        .d_req(d_req),
        .issue(issue),
        .gnt  (gnt)
    );

    always_comb begin
        state_d = IDLE;
        i_ack_d = 1'b0;
        d_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = resp_state(gnt);
                i_ack_d = (gnt == GNT_I);
                d_ack_d = (gnt == GNT_D);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_ack_q <= i_ack_d;
            d_ack_q <= d_ack_d;
        end
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        case (gnt)
            GNT_I: begin
                m_en   = 1'b1;
                m_addr = i_addr;
            end
            GNT_D: begin
                m_en    = 1'b1;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
            default: m_en = 1'b0;
        endcase
    end

    // A reset landing on the response cycle drops the access; the core reissues.
    assign i_ack   = i_ack_q && !reset;
    assign d_ack   = d_ack_q && !reset;
    assign i_rdata = i_ack ? m_rdata : '0;
    assign d_rdata = (d_ack && !d_we) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, per-port requesters and a scoreboard.
module tb_mem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAXB      = 4;
    localparam int WAIT_MAX  = 2 * (MAXB + 1);
    localparam int MEM_WORDS = 1024;
    localparam logic [7:0] ACK_I = 8'h49;
    localparam logic [7:0] ACK_D = 8'h44;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_DATA_BURST(MAXB)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    logic [DW-1:0] tb_mem  [MEM_WORDS];
    logic [DW-1:0] ref_mem [MEM_WORDS];

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) tb_mem[m_addr[11:2]] <= m_wdata;
            else      m_rdata <= tb_mem[m_addr[11:2]];
        end
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dcmd_t;

    logic [AW-1:0] i_cmd_q[$];
    dcmd_t         d_cmd_q[$];
    logic [DW-1:0] i_exp_q[$];
    logic [DW-1:0] d_exp_q[$];
    byte           ack_seq[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   i_wait   = 0;
    logic i_wait_ok = 1'b1;
    logic i_busy = 1'b0;
    logic d_busy = 1'b0;
    logic rnd_mode = 1'b0;
    logic rst_next = 1'b1;

    logic          s_reset, s_i_ack, s_d_ack, s_m_en, s_m_we;
    logic [DW-1:0] s_i_rdata, s_d_rdata, s_m_wdata;
    logic [AW-1:0] s_m_addr;
    logic          p_m_en = 1'b0;
    logic          p_m_we = 1'b0;
    logic [AW-1:0] p_m_addr = '0;
    logic [DW-1:0] p_m_wdata = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_init(input int idx);
        return 32'h5A5A_0000 ^ (32'(idx) * 32'h9E37_79B1);
    endfunction

    // Requester side: retire acked requests, present the next one, record expectations.
    task automatic drive();
        dcmd_t c;
        reset = rst_next;
        if (s_i_ack) begin i_busy = 1'b0; i_req = 1'b0; end
        if (s_d_ack) begin d_busy = 1'b0; d_req = 1'b0; end
        if (!i_busy && rnd_mode && i_cmd_q.size() == 0 && $urandom_range(0, 2) != 0)
            i_cmd_q.push_back({20'h0, 1'b0, 9'($urandom), 2'($urandom)});
        if (!i_busy && i_cmd_q.size() > 0) begin
            i_addr = i_cmd_q.pop_front();
            i_req  = 1'b1;
            i_busy = 1'b1;
            i_wait = 0;
            i_wait_ok = 1'b1;
            i_exp_q.push_back(ref_mem[i_addr[11:2]]);
        end
        if (!d_busy && rnd_mode && d_cmd_q.size() == 0 && $urandom_range(0, 2) != 0)
            d_cmd_q.push_back('{we: 1'($urandom), addr: {20'h0, 1'b1, 9'($urandom), 2'($urandom)},
                                wdata: $urandom});
        if (!d_busy && d_cmd_q.size() > 0) begin
            c = d_cmd_q.pop_front();
            d_we    = c.we;
            d_addr  = c.addr;
            d_wdata = c.wdata;
            d_req   = 1'b1;
            d_busy  = 1'b1;
            if (c.we) begin
                ref_mem[c.addr[11:2]] = c.wdata;
                d_exp_q.push_back('0);
            end else begin
                d_exp_q.push_back(ref_mem[c.addr[11:2]]);
            end
        end
    endtask

    task automatic sample();
        s_reset = reset;   s_i_ack = i_ack;   s_d_ack = d_ack;
        s_i_rdata = i_rdata; s_d_rdata = d_rdata;
        s_m_en = m_en; s_m_we = m_we; s_m_addr = m_addr; s_m_wdata = m_wdata;
        if (s_reset) begin
            check_eq("rst_m_en", s_m_en, 0);
            check_eq("rst_m_we", s_m_we, 0);
            check_eq("rst_acks", {s_i_ack, s_d_ack}, 0);
        end
        if (!s_m_en) check_eq("m_we_without_en", s_m_we, 0);
        if (s_i_ack || s_d_ack) begin
            check_eq("single_ack", s_i_ack & s_d_ack, 0);
            check_eq("no_issue_in_resp", s_m_en, 0);
        end
        if (p_m_en && !s_reset) check_eq("ack_after_issue", s_i_ack | s_d_ack, 1);
        if (s_i_ack) begin
            ack_seq.push_back(ACK_I);
            check_eq("i_issue_addr", p_m_addr, i_addr);
            check_eq("i_issue_we", p_m_we, 0);
            if (!s_d_ack) check_eq("i_resp_d_rdata_zero", s_d_rdata, 0);
            check_eq("i_outstanding", i_exp_q.size(), 1);
            if (i_exp_q.size() > 0) check_eq("i_rdata", s_i_rdata, i_exp_q.pop_front());
            if (i_wait_ok) check_eq("fetch_wait_bound", i_wait > WAIT_MAX, 0);
        end else if (i_busy) begin
            i_wait++;
            if (s_reset) i_wait_ok = 1'b0;
        end
        if (s_d_ack) begin
            ack_seq.push_back(ACK_D);
            check_eq("d_issue_addr", p_m_addr, d_addr);
            check_eq("d_issue_we", p_m_we, d_we);
            if (d_we) check_eq("d_issue_wdata", p_m_wdata, d_wdata);
            if (!s_i_ack) check_eq("d_resp_i_rdata_zero", s_i_rdata, 0);
            check_eq("d_outstanding", d_exp_q.size(), 1);
            if (d_exp_q.size() > 0) check_eq("d_rdata", s_d_rdata, d_exp_q.pop_front());
        end
        p_m_en = s_m_en; p_m_we = s_m_we; p_m_addr = s_m_addr; p_m_wdata = s_m_wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int k = 0;
        while (ack_seq.size() < n && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, ack_seq.size() >= n, 1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        rnd_mode = 1'b0;
        while ((i_busy || d_busy || i_cmd_q.size() > 0 || d_cmd_q.size() > 0) && k < budget) begin
            step();
            k++;
        end
        check_eq("drain_idle", {i_busy, d_busy}, 0);
    endtask

    task automatic check_burst_seq(input int n, input string tag);
        for (int k = 0; k < n; k++)
            check_eq(tag, ack_seq[k], (k % (MAXB + 1) == MAXB) ? ACK_I : ACK_D);
    endtask

    initial begin
        logic [DW-1:0] old_word;
        for (int k = 0; k < MEM_WORDS; k++) begin
            tb_mem[k]  = mem_init(k);
            ref_mem[k] = mem_init(k);
        end
        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        repeat (3) step();
        rst_next = 1'b0;
        step();
        check_eq("reset_i_ack", s_i_ack, 0);
        check_eq("reset_d_ack", s_d_ack, 0);
        check_eq("reset_i_rdata", s_i_rdata, 0);
        check_eq("reset_d_rdata", s_d_rdata, 0);
        check_eq("reset_m_en", s_m_en, 0);
        check_eq("reset_m_we", s_m_we, 0);
        check_eq("reset_m_addr", s_m_addr, 0);
        check_eq("reset_m_wdata", s_m_wdata, 0);

        // Single fetch: issue in cycle 0, ack with data in cycle 1.
        i_cmd_q.push_back(32'h0000_0004);
        step();
        check_eq("fetch_issue_en", s_m_en, 1);
        check_eq("fetch_issue_addr", s_m_addr, 32'h4);
        check_eq("fetch_issue_we", s_m_we, 0);
        step();
        check_eq("fetch_ack", s_i_ack, 1);
        check_eq("fetch_rdata", s_i_rdata, mem_init(1));

        // Store then load back from the same address.
        d_cmd_q.push_back('{we: 1'b1, addr: 32'h54, wdata: 32'hDEAD_BEEF});
        step();
        check_eq("store_issue_en", s_m_en, 1);
        check_eq("store_issue_we", s_m_we, 1);
        check_eq("store_issue_addr", s_m_addr, 32'h54);
        check_eq("store_issue_wdata", s_m_wdata, 32'hDEAD_BEEF);
        step();
        check_eq("store_ack", s_d_ack, 1);
        check_eq("store_ack_rdata", s_d_rdata, 0);
        d_cmd_q.push_back('{we: 1'b0, addr: 32'h54, wdata: 32'h0});
        step();
        step();
        check_eq("load_ack", s_d_ack, 1);
        check_eq("load_back_rdata", s_d_rdata, 32'hDEAD_BEEF);

        // Both ports busy from idle: data wins until the streak forces a fetch.
        ack_seq.delete();
        for (int k = 0; k < 12; k++) begin
            i_cmd_q.push_back(32'h100 + 32'(k * 4));
            d_cmd_q.push_back('{we: 1'b0, addr: 32'h800 + 32'(k * 4), wdata: 32'h0});
        end
        wait_acks(10, 60, "burst_timeout");
        if (ack_seq.size() >= 10) check_burst_seq(10, "grant_seq");
        i_cmd_q.delete();
        d_cmd_q.delete();
        drain(40);

        // Reset landing on the RESP_D cycle of a load, with streak at 2.
        ack_seq.delete();
        for (int k = 0; k < 10; k++) begin
            i_cmd_q.push_back(32'h200 + 32'(k * 4));
            d_cmd_q.push_back('{we: 1'b0, addr: 32'hA00 + 32'(k * 4), wdata: 32'h0});
        end
        wait_acks(2, 20, "pre_reset_timeout");
        step();
        check_eq("pre_reset_issue_en", s_m_en, 1);
        check_eq("pre_reset_issue_addr", s_m_addr, d_addr);
        rst_next = 1'b1;
        step();
        check_eq("rst_resp_d_ack", s_d_ack, 0);
        rst_next = 1'b0;
        ack_seq.delete();
        wait_acks(MAXB + 1, 40, "post_reset_timeout");
        if (ack_seq.size() >= MAXB + 1) check_burst_seq(MAXB + 1, "post_reset_seq");
        i_cmd_q.delete();
        d_cmd_q.delete();
        drain(40);

        // Reset in a store issue cycle must not write memory.
        old_word = tb_mem[10'h240];
        d_cmd_q.push_back('{we: 1'b1, addr: 32'h900, wdata: 32'h1234_5678});
        rst_next = 1'b1;
        step();
        check_eq("rst_store_m_en", s_m_en, 0);
        rst_next = 1'b0;
        step();
        check_eq("rst_store_no_write", tb_mem[10'h240], old_word);
        check_eq("reissue_store_en", s_m_en, 1);
        drain(10);
        check_eq("reissue_store_written", tb_mem[10'h240], 32'h1234_5678);
        d_cmd_q.push_back('{we: 1'b0, addr: 32'h900, wdata: 32'h0});
        drain(10);

        // Random traffic against the reference memory.
        rnd_mode = 1'b1;
        repeat (10000) step();
        drain(100);
        check_eq("i_scoreboard_empty", i_exp_q.size(), 0);
        check_eq("d_scoreboard_empty", d_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
